// File: rtl/arb_req_buffer_if.sv
// Handshake bundle for arb_req_buffer: per-port push side, arbiter req/grant,
// and the single registered output. Stall counters exist only with ARB_BUF_STALL_CNT_EN.
interface arb_req_buffer_if #(
   parameter int PORTS  = 4,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   logic [PORTS-1:0]        in_valid_i;
   logic [PORTS-1:0]        in_ready_o;
   logic [PORTS*DATA_W-1:0] in_data_i;
   logic [PORTS-1:0]        req_o;
   logic [PORTS-1:0]        grant_i;
   logic                    out_valid_o;
   logic                    out_ready_i;
   logic [DATA_W-1:0]       out_data_o;
   logic [PORT_W-1:0]       out_port_o;
`ifdef ARB_BUF_STALL_CNT_EN
   logic [PORTS*CNT_W-1:0]  stall_cnt_o;
`endif

   modport slave (
      input  in_valid_i,
      input  in_data_i,
      input  grant_i,
      input  out_ready_i,
      output in_ready_o,
      output req_o,
      output out_valid_o,
      output out_data_o,
`ifdef ARB_BUF_STALL_CNT_EN
      output stall_cnt_o,
`endif
      output out_port_o
   );

   modport master (
      output in_valid_i,
      output in_data_i,
      output grant_i,
      output out_ready_i,
      input  in_ready_o,
      input  req_o,
      input  out_valid_o,
      input  out_data_o,
`ifdef ARB_BUF_STALL_CNT_EN
      input  stall_cnt_o,
`endif
      input  out_port_o
   );
endinterface

// File: rtl/arb_req_buffer.sv
// Per-port FIFOs feeding a registered output stage steered by an external one-hot grant.
// Optional per-port saturating stall counters enabled by ARB_BUF_STALL_CNT_EN.
module arb_req_buffer #(
   parameter int PORTS  = 4,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2,
   parameter int CNT_W  = 16
) (
   input logic            clk_i,
   input logic            rst_i,
   arb_req_buffer_if.slave bus
);
   localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int CW     = AW + 1;

   logic [DATA_W-1:0] mem_q [PORTS][DEPTH];
   logic [DATA_W-1:0] mem_d [PORTS][DEPTH];
   logic [AW-1:0]     wr_ptr_q [PORTS];
   logic [AW-1:0]     wr_ptr_d [PORTS];
   logic [AW-1:0]     rd_ptr_q [PORTS];
   logic [AW-1:0]     rd_ptr_d [PORTS];
   logic [CW-1:0]     cnt_q [PORTS];
   logic [CW-1:0]     cnt_d [PORTS];

   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [PORT_W-1:0] out_port_q, out_port_d;

   logic [PORTS-1:0]  full;
   logic [PORTS-1:0]  in_ready;
   logic [PORTS-1:0]  req;
   logic [PORTS-1:0]  hit;
   logic [PORTS-1:0]  push;
   logic [PORTS-1:0]  pop;
   logic [PORT_W-1:0] win;
   logic              win_vld;
   logic              load;

   // Status is derived from registered counts only, so req/ready never
   // depend combinationally on this cycle's valid or grant.
   always_comb begin
      full     = '0;
      in_ready = '0;
      req      = '0;
      for (int p = 0; p < PORTS; p++) begin
         full[p]     = (cnt_q[p] == CW'(DEPTH));
         in_ready[p] = !full[p] && !rst_i;
         req[p]      = (cnt_q[p] != '0);
      end
   end

   always_comb begin
      hit     = bus.grant_i & req;
      win_vld = |hit;
      win     = '0;
      for (int p = PORTS - 1; p >= 0; p--) begin
         if (hit[p]) win = PORT_W'(p);
      end
      load = !out_valid_q || bus.out_ready_i;
      pop  = '0;
      if (load && win_vld) pop[win] = 1'b1;
      push = bus.in_valid_i & in_ready;
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      for (int p = 0; p < PORTS; p++) begin
         if (push[p]) begin
            mem_d[p][wr_ptr_q[p]] = bus.in_data_i[p*DATA_W +: DATA_W];
            wr_ptr_d[p] = wr_ptr_q[p] + AW'(1);
         end
         if (pop[p]) rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
         cnt_d[p] = cnt_q[p] + CW'(push[p]) - CW'(pop[p]);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_port_d  = out_port_q;
      if (load) begin
         out_valid_d = win_vld;
         if (win_vld) begin
            out_data_d = mem_q[win][rd_ptr_q[win]];
            out_port_d = win;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < PORTS; p++) begin
            for (int d = 0; d < DEPTH; d++) mem_q[p][d] <= '0;
            wr_ptr_q[p] <= '0;
            rd_ptr_q[p] <= '0;
            cnt_q[p]    <= '0;
         end
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_port_q  <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_port_q  <= out_port_d;
      end
   end

`ifdef ARB_BUF_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q [PORTS];
   logic [CNT_W-1:0] stall_d [PORTS];

   // A port stalls in any cycle it requests but is not the one popped.
   always_comb begin
      stall_d = stall_q;
      for (int p = 0; p < PORTS; p++) begin
         if (req[p] && !pop[p] && (stall_q[p] != '1))
            stall_d[p] = stall_q[p] + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < PORTS; p++) stall_q[p] <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   always_comb begin
      bus.stall_cnt_o = '0;
      for (int p = 0; p < PORTS; p++)
         bus.stall_cnt_o[p*CNT_W +: CNT_W] = stall_q[p];
   end
`endif

   assign bus.in_ready_o  = in_ready;
   assign bus.req_o       = req;
   assign bus.out_valid_o = out_valid_q;
   assign bus.out_data_o  = out_data_q;
   assign bus.out_port_o  = out_port_q;
endmodule

// File: tb/tb_arb_req_buffer.sv
// Directed bench for arb_req_buffer with a fixed-priority arbiter model
// closing the req/grant loop (overridable to force specific grants).
module tb_arb_req_buffer;
   localparam int PORTS  = 4;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   logic             grant_mode = 1'b0;
   logic [PORTS-1:0] grant_force = '0;

   logic [31:0] exp_data [8];
   logic [1:0]  exp_port [8];

   arb_req_buffer_if #(.PORTS(PORTS), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   arb_req_buffer #(
      .PORTS(PORTS), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (grant_mode) bus.grant_i = grant_force;
      else            bus.grant_i = bus.req_o & (~bus.req_o + 4'd1);
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int p, input logic [31:0] v);
      bus.in_data_i[p*DATA_W +: DATA_W] = v;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid_i  = '0;
      bus.in_data_i   = '0;
      bus.out_ready_i = 1'b0;

      // reset state
      #2;
      check("rst_valid", bus.out_valid_o, 0);
      check("rst_req", bus.req_o, 0);
      check("rst_ready", bus.in_ready_o, 0);
      check("rst_data", bus.out_data_o, 0);
      check("rst_port", bus.out_port_o, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("rel_ready", bus.in_ready_o, 4'hf);
      bus.out_ready_i = 1'b1;

      // single port latency
      bus.in_valid_i = 4'b0100;
      set_data(2, 32'hA5);
      step();
      bus.in_valid_i = '0;
      check("sp_req", bus.req_o, 4'b0100);
      check("sp_valid_n1", bus.out_valid_o, 0);
      step();
      check("sp_valid_n2", bus.out_valid_o, 1);
      check("sp_data", bus.out_data_o, 32'hA5);
      check("sp_port", bus.out_port_o, 2);
      check("sp_req_clr", bus.req_o, 0);
      step();
      check("sp_drop", bus.out_valid_o, 0);
      check("sp_hold", bus.out_data_o, 32'hA5);

      // contention between ports 0 and 3
      bus.in_valid_i = 4'b1001;
      set_data(0, 32'h100);
      set_data(3, 32'h300);
      step();
      set_data(0, 32'h101);
      set_data(3, 32'h301);
      step();
      bus.in_valid_i = '0;
      check("ct_d0", bus.out_data_o, 32'h100);
      check("ct_p0", bus.out_port_o, 0);
      step();
      check("ct_d1", bus.out_data_o, 32'h101);
      check("ct_p1", bus.out_port_o, 0);
      step();
      check("ct_d2", bus.out_data_o, 32'h300);
      check("ct_p2", bus.out_port_o, 3);
      step();
      check("ct_d3", bus.out_data_o, 32'h301);
      check("ct_p3", bus.out_port_o, 3);
      step();
      check("ct_end", bus.out_valid_o, 0);

      // backpressure with all FIFOs full
      bus.out_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus.in_valid_i = 4'hf;
         for (int p = 0; p < PORTS; p++) set_data(p, 32'(p * 16 + k));
         step();
      end
      bus.in_valid_i = '0;
      check("bp_ready", bus.in_ready_o, 0);
      check("bp_req", bus.req_o, 4'hf);
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", bus.out_valid_o, 1);
         check("bp_data", bus.out_data_o, 32'h00);
         check("bp_port", bus.out_port_o, 0);
         step();
      end
      check("bp_ready2", bus.in_ready_o, 0);
      exp_data = '{32'h01, 32'h02, 32'h10, 32'h11,
                   32'h20, 32'h21, 32'h30, 32'h31};
      exp_port = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         check("bp_drain_v", bus.out_valid_o, 1);
         check("bp_drain_d", bus.out_data_o, 64'(exp_data[i]));
         check("bp_drain_p", bus.out_port_o, 64'(exp_port[i]));
      end
      step();
      check("bp_end", bus.out_valid_o, 0);

      // full FIFO refuses push in the cycle its head pops
      grant_mode  = 1'b1;
      grant_force = '0;
      bus.in_valid_i = 4'b0010;
      set_data(1, 32'h41);
      step();
      set_data(1, 32'h42);
      step();
      set_data(1, 32'h43);
      check("ff_full", bus.in_ready_o[1], 0);
      check("ff_idle", bus.out_valid_o, 0);
      grant_force = 4'b0010;
      step();
      grant_force = '0;
      check("ff_pop_d", bus.out_data_o, 32'h41);
      check("ff_pop_p", bus.out_port_o, 1);
      check("ff_room", bus.in_ready_o[1], 1);
      step();
      bus.in_valid_i = '0;
      check("ff_acc", bus.in_ready_o[1], 0);
      check("ff_nogrant", bus.out_valid_o, 0);
      grant_mode = 1'b0;
      step();
      check("ff_d1", bus.out_data_o, 32'h42);
      step();
      check("ff_d2", bus.out_data_o, 32'h43);
      step();
      check("ff_end", bus.out_valid_o, 0);

      // grant to empty port, then multi-hot grant
      grant_mode = 1'b1;
      bus.in_valid_i = 4'b1010;
      set_data(1, 32'h55);
      set_data(3, 32'h77);
      step();
      bus.in_valid_i = '0;
      grant_force = 4'b0100;
      step();
      check("eg_valid", bus.out_valid_o, 0);
      check("eg_req", bus.req_o, 4'b1010);
      grant_force = 4'b1010;
      step();
      check("mh_data", bus.out_data_o, 32'h55);
      check("mh_port", bus.out_port_o, 1);
      check("mh_req", bus.req_o, 4'b1000);
      grant_mode = 1'b0;
      step();
      check("mh_d2", bus.out_data_o, 32'h77);
      check("mh_p2", bus.out_port_o, 3);
      step();

      // asynchronous reset mid-burst
      bus.out_ready_i = 1'b0;
      bus.in_valid_i  = 4'hf;
      for (int p = 0; p < PORTS; p++) set_data(p, 32'hC0 + 32'(p));
      step();
      step();
      check("mr_pre", bus.out_valid_o, 1);
      #3 rst = 1'b1;
      #1;
      check("mr_valid", bus.out_valid_o, 0);
      check("mr_req", bus.req_o, 0);
      check("mr_ready", bus.in_ready_o, 0);
      check("mr_data", bus.out_data_o, 0);
      bus.in_valid_i = '0;
      @(posedge clk);
      #1 rst = 1'b0;
      #1 check("mr_rel", bus.in_ready_o, 4'hf);
      check("mr_req2", bus.req_o, 0);
      bus.out_ready_i = 1'b1;
      step();
      check("mr_empty", bus.out_valid_o, 0);

`ifdef ARB_BUF_STALL_CNT_EN
      // port 3 starved by port 0
      bus.in_valid_i = 4'b1001;
      set_data(0, 32'hE0);
      set_data(3, 32'hE3);
      step();
      bus.in_valid_i = 4'b0001;
      repeat (5) step();
      check("st_p3_5", bus.stall_cnt_o[3*CNT_W +: CNT_W], 5);
      check("st_p0", bus.stall_cnt_o[0 +: CNT_W], 0);
      repeat (15) step();
      check("st_p3_sat", bus.stall_cnt_o[3*CNT_W +: CNT_W], 15);
      bus.in_valid_i = '0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
